fifo_gen2: RTL and testbench

Parametrised synchronous FIFO, the second-generation buffer for the FIFO verification environment. Configurable width and depth (including non-power-of-two), programmable almost-full/almost-empty thresholds, an occupancy count output, and a synchronous flush. Offers either standard registered-read or first-word-fall-through (FWFT) output. It is a drop-in buffering stage between a single producer and a single consumer in one clock domain.

---
 rtl/fifo_pkg.sv | 9 +
 rtl/fifo_mem.sv | 18 +
 rtl/fifo_gen2.sv | 86 ++++++++
 tb/tb_fifo_gen2.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, output-mode enum and explicit-wrap pointer increment for fifo_gen2
package fifo_pkg;
  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH simple dual-port array; ports clk, we/waddr/wdata (sync write), raddr/rdata (async read)
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_gen2.sv
// fifo_gen2: sync FIFO (std/FWFT) with count, flags, flush; ports clk, rst, flush, wr_en/data_in, rd_en/data_out, wr_ack, overflow, underflow, count, full/empty/almostfull/almostempty
module fifo_gen2 import fifo_pkg::*; #(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       wr_ack,
  output logic                       overflow,
  output logic                       underflow,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almostfull,
  output logic                       almostempty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT = CW'(AE_LEVEL);
  if (WIDTH < 1 || DEPTH < 2) begin : g_bad_size
    $error("fifo_gen2: WIDTH must be >= 1 and DEPTH >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1 || AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_level
    $error("fifo_gen2: AF_LEVEL and AE_LEVEL must lie in 1..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
    $error("fifo_gen2: FWFT must be 0 or 1");
  end
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem_rd, dout_q;
  logic             rd_ok, wr_ok;
  assign full        = count == FULL_CNT;
  assign empty       = count == '0;
  assign almostfull  = count >= AF_CNT && !full;
  assign almostempty = !empty && count <= AE_CNT;
  // a full FIFO still takes a write when a read frees a slot in the same cycle
  assign rd_ok = !flush && rd_en && !empty;
  assign wr_ok = !flush && wr_en && (!full || rd_ok);
  // FWFT shows the head directly; dout_q keeps the last popped word for when it drains
  assign data_out = (MODE == FIFO_FWFT && !empty) ? mem_rd : dout_q;
  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rd)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout_q    <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= !flush && wr_en && !wr_ok;
      underflow <= !flush && rd_en && !rd_ok;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_ok) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
        if (rd_ok) begin
          rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
          dout_q <= mem_rd;
        end
        if (wr_ok != rd_ok) count <= wr_ok ? count + CW'(1) : count - CW'(1);
      end
    end
endmodule

// File: tb/tb_fifo_gen2.sv
// tb_fifo_gen2: queue-model check of a default std FIFO and a DEPTH=5 FWFT FIFO, directed scenarios then random traffic
module tb_fifo_gen2;
  logic        clk = 0, rst = 0, flush = 0, wr_en = 0, rd_en = 0;
  logic [15:0] data_in = 0;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int D  = g ? 5 : 8;
    localparam int AF = g ? 3 : 7;
    localparam int AE = g ? 2 : 1;
    localparam int CW = $clog2(D + 1);
    logic [15:0]   data_out;
    logic          wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
    logic [CW-1:0] count;
    fifo_gen2 #(.WIDTH(16), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(g)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .wr_en       (wr_en),
      .data_in     (data_in),
      .rd_en       (rd_en),
      .data_out    (data_out),
      .wr_ack      (wr_ack),
      .overflow    (overflow),
      .underflow   (underflow),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almostfull  (almostfull),
      .almostempty (almostempty)
    );
    logic [15:0] q[$];
    logic [15:0] m_dout = 0;
    logic        m_ack = 0, m_ov = 0, m_un = 0;
    always @(posedge clk) begin
      logic        f, w, r, rs, rok, wok;
      logic [15:0] d, hd;
      logic [26:0] e, a;
      int          n;
      f = flush; w = wr_en; r = rd_en; rs = rst; d = data_in;
      if (rs) begin
        q.delete(); m_dout = 0; m_ack = 0; m_ov = 0; m_un = 0;
      end else if (f) begin
        q.delete(); m_ack = 0; m_ov = 0; m_un = 0;
      end else begin
        rok = r && q.size() > 0;
        wok = w && (q.size() < D || rok);
        m_ack = wok; m_ov = w && !wok; m_un = r && !rok;
        if (rok) m_dout = q.pop_front();
        if (wok) q.push_back(d);
      end
      #1;
      n  = q.size();
      hd = (g != 0 && n != 0) ? q[0] : m_dout;
      e = {hd, m_ack, m_ov, m_un, 4'(n), n == D, n == 0, n >= AF && n != D, n != 0 && n <= AE};
      a = {data_out, wr_ack, overflow, underflow, 4'(count), full, empty, almostfull, almostempty};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model[%0d] t=%0t: dut {dout,ack,ov,un,cnt,f,e,af,ae}=%h expected %h", g, $time, a, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic [15:0] d);
    wr_en = w; rd_en = r; flush = f; data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1;
    repeat (2) @(negedge clk);
    chk("reset empty", 32'(g_i[0].empty), 1);
    chk("reset count", 32'(g_i[0].count), 0);
    chk("reset data_out", 32'(g_i[0].data_out), 0);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 16'hA000 + 16'(i));
      chk("fill wr_ack", 32'(g_i[0].wr_ack), 1);
      chk("fill count", 32'(g_i[0].count), 32'(i + 1));
      chk("fill almostfull", 32'(g_i[0].almostfull), 32'(i == 6));
      chk("fill full", 32'(g_i[0].full), 32'(i == 7));
    end
    step(1, 0, 0, 16'hA008);
    chk("9th overflow", 32'(g_i[0].overflow), 1);
    chk("9th wr_ack", 32'(g_i[0].wr_ack), 0);
    chk("9th count", 32'(g_i[0].count), 8);
    step(1, 1, 0, 16'hBEEF);
    chk("full rw count", 32'(g_i[0].count), 8);
    chk("full rw overflow", 32'(g_i[0].overflow), 0);
    chk("full rw wr_ack", 32'(g_i[0].wr_ack), 1);
    chk("full rw data", 32'(g_i[0].data_out), 32'h A000);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0);
      chk("drain data", 32'(g_i[0].data_out), i == 8 ? 32'hBEEF : 32'hA000 + 32'(i));
    end
    step(0, 1, 0, 0);
    chk("underflow pulse", 32'(g_i[0].underflow), 1);
    chk("underflow count", 32'(g_i[0].count), 0);
    chk("underflow data holds", 32'(g_i[0].data_out), 32'hBEEF);
    step(0, 0, 0, 0);
    chk("underflow one cycle", 32'(g_i[0].underflow), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 16'h0100 + 16'(i));
      step(0, 1, 0, 0);
      chk("wrap data", 32'(g_i[0].data_out), 32'h100 + 32'(i));
    end
    step(1, 0, 0, 16'h1234);
    chk("fwft data", 32'(g_i[1].data_out), 32'h1234);
    chk("fwft almostempty", 32'(g_i[1].almostempty), 1);
    chk("fwft not empty", 32'(g_i[1].empty), 0);
    step(0, 1, 0, 0);
    chk("fwft pop empty", 32'(g_i[1].empty), 1);
    chk("fwft data holds", 32'(g_i[1].data_out), 32'h1234);
    chk("std read 1234", 32'(g_i[0].data_out), 32'h1234);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'hC000 + 16'(i));
    chk("loaded count", 32'(g_i[0].count), 5);
    step(1, 0, 1, 16'hDEAD);
    chk("flush count", 32'(g_i[0].count), 0);
    chk("flush empty", 32'(g_i[0].empty), 1);
    chk("flush no ack", 32'(g_i[0].wr_ack), 0);
    chk("flush data holds", 32'(g_i[0].data_out), 32'h1234);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'hD000 + 16'(i));
    wr_en = 0;
    chk("reload head", 32'(g_i[1].data_out), 32'hD000);
    #2 rst = 1;
    #1;
    chk("async rst count", 32'(g_i[0].count), 0);
    chk("async rst empty", 32'(g_i[0].empty), 1);
    chk("async rst wr_ack", 32'(g_i[0].wr_ack), 0);
    chk("async rst data_out", 32'(g_i[0].data_out), 0);
    chk("async rst fwft data", 32'(g_i[1].data_out), 0);
    chk("async rst almostempty", 32'(g_i[1].almostempty), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4000; i++) begin
      wr_en   = $urandom_range(0, 99) < (i < 2000 ? 65 : 35);
      rd_en   = $urandom_range(0, 99) < (i < 2000 ? 35 : 65);
      flush   = $urandom_range(0, 63) == 0;
      data_in = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
